// File: rtl/pwm_capture.sv
// Purpose: measures high-time and period of an asynchronous PWM input, with stuck-high/low detection. Optional glitch filter: PWM_CAP_FILTER_EN.
// Latency: valid on the 3rd clk edge after the pwm_in rise that closes a period (5th with PWM_CAP_FILTER_EN).
// Backpressure: none; pwm_in is sampled every cycle and each result is a single-cycle valid pulse.
`timescale 1ns/1ps

module pwm_capture #(
    parameter int CNT_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] intensity,
    output logic [CNT_W-1:0] period,
    output logic             valid,
    output logic             stuck_hi,
    output logic             stuck_lo
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARM,
        ST_HIGH,
        ST_LOW
    } state_t;

    logic             r_sync1;
    logic             r_sync2;
    logic             r_pwm_d;
    logic             w_pwm_s;
    logic             w_rise;
    logic             w_fall;
    state_t           r_state;
    logic [CNT_W-1:0] r_hi_cnt;
    logic [CNT_W-1:0] r_per_cnt;
    logic [CNT_W-1:0] r_intensity;
    logic [CNT_W-1:0] r_period;
    logic             r_valid;
    logic             r_stuck_hi;
    logic             r_stuck_lo;

    // Two-flop synchronizer bringing the asynchronous PWM into the clk domain.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= pwm_in;
            r_sync2 <= r_sync1;
        end
    end

`ifdef PWM_CAP_FILTER_EN
    logic r_flt_h1;
    logic r_flt_h2;
    logic w_flt_all_hi;
    logic w_flt_all_lo;

    // Two previous synchronized samples; together with r_sync2 they form the 3-sample window.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_flt_h1 <= 1'b0;
            r_flt_h2 <= 1'b0;
        end else begin
            r_flt_h1 <= r_sync2;
            r_flt_h2 <= r_flt_h1;
        end
    end

    // The filtered level follows the window only when all three samples agree,
    // otherwise it holds its previous value (r_pwm_d is exactly that value).
    assign w_flt_all_hi = r_sync2 & r_flt_h1 & r_flt_h2;
    assign w_flt_all_lo = ~(r_sync2 | r_flt_h1 | r_flt_h2);
    assign w_pwm_s      = w_flt_all_hi ? 1'b1 : (w_flt_all_lo ? 1'b0 : r_pwm_d);
`else
    assign w_pwm_s = r_sync2;
`endif

    // One-cycle delayed copy of the conditioned level for edge detection.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pwm_d <= 1'b0;
        end else begin
            r_pwm_d <= w_pwm_s;
        end
    end

    assign w_rise = w_pwm_s & ~r_pwm_d;
    assign w_fall = ~w_pwm_s & r_pwm_d;

    // Measurement FSM: arm on a fall, start on a rise, publish on the next rise.
    // Counters saturate into a timeout instead of wrapping; an edge in the
    // same cycle as the limit takes priority over the timeout.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_hi_cnt    <= CNT_ZERO;
            r_per_cnt   <= CNT_ZERO;
            r_intensity <= CNT_ZERO;
            r_period    <= CNT_ZERO;
            r_valid     <= 1'b0;
            r_stuck_hi  <= 1'b0;
            r_stuck_lo  <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // A rise here would start a partial period, so only a fall arms.
                    if (w_fall) begin
                        r_state <= ST_ARM;
                    end
                end
                ST_ARM: begin
                    if (w_rise) begin
                        r_state   <= ST_HIGH;
                        r_hi_cnt  <= CNT_ONE;
                        r_per_cnt <= CNT_ONE;
                    end
                end
                ST_HIGH: begin
                    if (w_fall) begin
                        r_state   <= ST_LOW;
                        r_per_cnt <= r_per_cnt + CNT_ONE;
                    end else if (r_per_cnt == CNT_MAX) begin
                        r_state     <= ST_IDLE;
                        r_intensity <= CNT_MAX;
                        r_period    <= CNT_MAX;
                        r_stuck_hi  <= 1'b1;
                        r_valid     <= 1'b1;
                    end else begin
                        r_per_cnt <= r_per_cnt + CNT_ONE;
                        r_hi_cnt  <= r_hi_cnt + CNT_ONE;
                    end
                end
                ST_LOW: begin
                    if (w_rise) begin
                        r_state     <= ST_HIGH;
                        r_intensity <= r_hi_cnt;
                        r_period    <= r_per_cnt;
                        r_valid     <= 1'b1;
                        r_stuck_hi  <= 1'b0;
                        r_stuck_lo  <= 1'b0;
                        r_hi_cnt    <= CNT_ONE;
                        r_per_cnt   <= CNT_ONE;
                    end else if (r_per_cnt == CNT_MAX) begin
                        r_state     <= ST_IDLE;
                        r_intensity <= CNT_ZERO;
                        r_period    <= CNT_MAX;
                        r_stuck_lo  <= 1'b1;
                        r_valid     <= 1'b1;
                    end else begin
                        r_per_cnt <= r_per_cnt + CNT_ONE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign intensity = r_intensity;
    assign period    = r_period;
    assign valid     = r_valid;
    assign stuck_hi  = r_stuck_hi;
    assign stuck_lo  = r_stuck_lo;

endmodule

// File: tb/tb_pwm_capture.sv
// Purpose: self-checking bench for pwm_capture against a timestamp-based reference model.
// Latency: model predicts every output every cycle, including valid timing.
// Backpressure: not applicable; stimulus is a free-running PWM waveform.
`timescale 1ns/1ps

module tb_pwm_capture;

    localparam int CNT_W   = 10;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             pwm_in;
    logic [CNT_W-1:0] intensity;
    logic [CNT_W-1:0] period;
    logic             valid;
    logic             stuck_hi;
    logic             stuck_lo;

    int n_chk = 0;
    int n_err = 0;

    // Reference model: input history plus timestamps of the measured edges.
    logic [4:0] hist;
    logic       prev_s;
    bit         armed;
    int         t_rise;
    int         t_fall;
    int         cyc;
    int         exp_int, exp_per, exp_vld, exp_shi, exp_slo;

    pwm_capture #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .pwm_in    (pwm_in),
        .intensity (intensity),
        .period    (period),
        .valid     (valid),
        .stuck_hi  (stuck_hi),
        .stuck_lo  (stuck_lo)
    );

    always #5 clk = ~clk;

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0d, want %0d", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        hist    = '0;
        prev_s  = 1'b0;
        armed   = 1'b0;
        t_rise  = -1;
        t_fall  = -1;
        exp_int = 0;
        exp_per = 0;
        exp_vld = 0;
        exp_shi = 0;
        exp_slo = 0;
    endtask

    // Advance the model by one cycle. The level seen by the measurement is the
    // input driven two cycles earlier (hist[2]); with the filter it only moves
    // once three consecutive such samples agree.
    task automatic model_step();
        logic s;
        logic rise;
        logic fall;
`ifdef PWM_CAP_FILTER_EN
        s = (hist[2] == hist[3] && hist[3] == hist[4]) ? hist[2] : prev_s;
`else
        s = hist[2];
`endif
        rise    = s & ~prev_s;
        fall    = ~s & prev_s;
        prev_s  = s;
        exp_vld = 0;
        if (t_rise < 0) begin
            if (!armed) begin
                if (fall) armed = 1'b1;
            end else if (rise) begin
                armed  = 1'b0;
                t_rise = cyc;
                t_fall = -1;
            end
        end else if (t_fall < 0) begin
            if (fall) begin
                t_fall = cyc;
            end else if (cyc - t_rise == CNT_MAX) begin
                exp_int = CNT_MAX;
                exp_per = CNT_MAX;
                exp_shi = 1;
                exp_vld = 1;
                t_rise  = -1;
            end
        end else begin
            if (rise) begin
                exp_int = t_fall - t_rise;
                exp_per = cyc - t_rise;
                exp_vld = 1;
                exp_shi = 0;
                exp_slo = 0;
                t_rise  = cyc;
                t_fall  = -1;
            end else if (cyc - t_rise == CNT_MAX) begin
                exp_int = 0;
                exp_per = CNT_MAX;
                exp_slo = 1;
                exp_vld = 1;
                t_rise  = -1;
            end
        end
    endtask

    // One clock cycle: compare DUT against the model, then drive the next inputs.
    task automatic tick(input logic v, input logic r);
        @(negedge clk);
        chk_val("intensity", 32'(intensity), exp_int);
        chk_val("period",    32'(period),    exp_per);
        chk_val("valid",     32'(valid),     exp_vld);
        chk_val("stuck_hi",  32'(stuck_hi),  exp_shi);
        chk_val("stuck_lo",  32'(stuck_lo),  exp_slo);
        rst    = r;
        pwm_in = v;
        hist   = {hist[3:0], v};
        if (!r) model_reset();
        else    model_step();
        cyc++;
    endtask

    task automatic seg(input logic v, input int n);
        for (int i = 0; i < n; i++) tick(v, 1'b1);
    endtask

    task automatic pwm_periods(input int hi, input int lo, input int n);
        for (int i = 0; i < n; i++) begin
            seg(1'b1, hi);
            seg(1'b0, lo);
        end
    endtask

    initial begin
        logic lvl;
        int   len;
        rst    = 1'b0;
        pwm_in = 1'b0;
        cyc    = 0;
        model_reset();

        // Reset state.
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0);

        // 300/723 waveform: results from the second full period on.
        pwm_periods(300, 723, 4);
        chk_val("dir_300_int", 32'(intensity), 300);
        chk_val("dir_300_per", 32'(period), 1023);

        // Reset in the middle of a high phase discards the partial measurement.
        seg(1'b1, 150);
        tick(1'b1, 1'b0);
        seg(1'b1, 149);
        seg(1'b0, 723);
        pwm_periods(300, 723, 3);
        chk_val("dir_rst_int", 32'(intensity), 300);

        // Held high: stuck_hi timeout, then cleared by a normal period.
        seg(1'b1, 2000);
        chk_val("dir_shi_flag", 32'(stuck_hi), 1);
        chk_val("dir_shi_int", 32'(intensity), 1023);
        seg(1'b0, 723);
        pwm_periods(300, 723, 2);
        chk_val("dir_shi_clr", 32'(stuck_hi), 0);

        // Held low mid-period: stuck_lo timeout.
        seg(1'b1, 50);
        seg(1'b0, 1500);
        chk_val("dir_slo_flag", 32'(stuck_lo), 1);
        chk_val("dir_slo_int", 32'(intensity), 0);

        // Shortest periods, and the edge-versus-limit boundary.
        pwm_periods(1, 1, 20);
`ifndef PWM_CAP_FILTER_EN
        chk_val("dir_p2_int", 32'(intensity), 1);
        chk_val("dir_p2_per", 32'(period), 2);
`endif
        pwm_periods(1, 1022, 3);
`ifndef PWM_CAP_FILTER_EN
        chk_val("dir_1022_per", 32'(period), 1023);
        chk_val("dir_1022_slo", 32'(stuck_lo), 0);
`endif

        // Randomized segments: mostly short, some around the timeout limit,
        // with an occasional reset.
        lvl = 1'b1;
        for (int k = 0; k < 80; k++) begin
            if ($urandom_range(0, 9) == 0) len = $urandom_range(1000, 1100);
            else                           len = $urandom_range(1, 60);
            if ($urandom_range(0, 29) == 0) tick(lvl, 1'b0);
            seg(lvl, len);
            lvl = ~lvl;
        end
        seg(1'b0, 40);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/pwm_capture.md
PWM_CAPTURE -- requirements
Module: pwm_capture

Interface
REQ-001 CNT_W, 10, width of the measurement counters and of the intensity/period outputs; CNT_MAX = 2^CNT_W-1.
REQ-002 clk  input  1  single clock; all flops clocked on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-low.
REQ-004 pwm_in  input  1  asynchronous PWM waveform, as driven on ctl by the team's PWM generator.
REQ-005 intensity  output  CNT_W  high-time of last complete period, in clk cycles.
REQ-006 period  output  CNT_W  length of last complete period, in clk cycles.
REQ-007 valid  output  1  one-cycle pulse when intensity/period are updated.
REQ-008 stuck_hi  output  1  pwm_in held high for CNT_MAX cycles without an edge.
REQ-009 stuck_lo  output  1  pwm_in held low for CNT_MAX cycles without an edge.

Function
REQ-010 pwm_in SHALL pass a 2-flop synchronizer giving pwm_s; pwm_d = pwm_s delayed one cycle; rise = pwm_s & ~pwm_d; fall = ~pwm_s & pwm_d.
REQ-011 FSM states SHALL be IDLE, ARM, HIGH, LOW; reset state IDLE.
REQ-012 IDLE: on fall -> ARM; a rise in IDLE SHALL be ignored (no partial period is ever measured).
REQ-013 ARM: on rise -> HIGH, hi_cnt <= 1, per_cnt <= 1.
REQ-014 HIGH: per_cnt and hi_cnt increment each cycle; on fall -> LOW (per_cnt increments, hi_cnt holds).
REQ-015 LOW: per_cnt increments each cycle; on rise -> publish, hi_cnt <= 1, per_cnt <= 1, next state HIGH.
REQ-016 Publish: intensity <= hi_cnt, period <= per_cnt, valid <= 1 for exactly one cycle, stuck_hi <= 0, stuck_lo <= 0.
REQ-017 intensity and period SHALL hold their value between publishes.
REQ-018 Counters SHALL never wrap; in HIGH or LOW, if per_cnt == CNT_MAX and no edge this cycle -> timeout.
REQ-019 Timeout in HIGH: intensity <= CNT_MAX, period <= CNT_MAX, stuck_hi <= 1, valid pulse, state IDLE.
REQ-020 Timeout in LOW: intensity <= 0, period <= CNT_MAX, stuck_lo <= 1, valid pulse, state IDLE.
REQ-021 Stuck flags SHALL stay set until the next normal publish or reset.
REQ-022 Latency: valid SHALL assert on the 3rd rising clk edge after the pwm_in rise that ends a period (2 sync + 1 output register).
REQ-023 Edge plus timeout in the same cycle: the edge SHALL win (normal publish/transition).
REQ-024 A pulse with period 1 cycle (rise on consecutive cycles impossible) is not required; minimum measurable high or low time is 1 cycle.

Reset
REQ-025 rst low at a rising clk edge SHALL clear synchronizer, pwm_d, hi_cnt, per_cnt, intensity, period, valid, stuck_hi, stuck_lo to 0 and set state IDLE, regardless of current state.
REQ-026 Reset asserted mid-period SHALL discard the partial measurement; after release the first publish follows a fall, a rise and a full period.

Configuration
REQ-027 Macro PWM_CAP_FILTER_EN: when defined, a 3-sample glitch filter SHALL sit after the synchronizer; its output changes only when 3 consecutive synchronized samples agree, rejecting pulses shorter than 3 cycles and adding 2 cycles to REQ-022 latency (valid on 5th edge); filter state resets to 0.
REQ-028 When PWM_CAP_FILTER_EN is undefined, pwm_s SHALL be the synchronizer output directly and no filter logic exists.

Verification
REQ-029 pwm_in high 300 cycles, low 723, repeated -> from second period onward valid pulses every 1023 cycles with intensity=300, period=1023.
REQ-030 pwm_in held high 2000 cycles after arming -> valid with intensity=1023, period=1023, stuck_hi=1; next normal period clears stuck_hi.
REQ-031 pwm_in held low after arming -> valid with intensity=0, period=1023, stuck_lo=1, state IDLE.
REQ-032 rst low for 1 cycle at cycle 150 of a 300/723 waveform -> all outputs 0 next cycle; no valid until one full period after the next fall.
REQ-033 pwm_in high 1, low 1 (period 2) -> intensity=1, period=2 each publish; valid on 3rd edge after rise (5th with PWM_CAP_FILTER_EN, where 1-cycle pulses are instead rejected and no valid occurs).
REQ-034 pwm_in high 1 cycle, low 1022 -> intensity=1, period=1023, no timeout asserted.
